// File: rtl/uart_pkg.sv
// uart_pkg: state, field encodings and constants shared by the UART TX and RX cores.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
    typedef enum logic [1:0] {BITS_5, BITS_6, BITS_7, BITS_8} data_bits_e;
    localparam int unsigned DATA_BITS_BASE = 5;
    function automatic logic [3:0] data_bit_count(input data_bits_e f);
        return 4'(DATA_BITS_BASE) + 4'(f);
    endfunction
endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts baud ticks within one serial bit and flags the tick that ends it.
module uart_tx_bit_timer #(
    parameter int OSR = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic tick,
    output logic bit_end
);
    localparam int CW = $clog2(OSR);
    logic [CW-1:0] cnt;
    assign bit_end = tick && cnt == CW'(OSR - 1);
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (tick) cnt <= bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter, start + 5-8 data bits LSB first + 1/2 stop bits.
// Parity bit support is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_core import uart_pkg::*; #(
    parameter int OSR        = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_baud_tick,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_data_bits,
    input  logic                  i_stop_2,
    input  logic                  i_parity_en,
    input  logic                  i_parity_odd,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam logic [2:0] S_IDLE   = 3'(IDLE);
    localparam logic [2:0] S_START  = 3'(START);
    localparam logic [2:0] S_DATA   = 3'(DATA);
    localparam logic [2:0] S_PARITY = 3'(PARITY);
    localparam logic [2:0] S_STOP   = 3'(STOP);

    logic [2:0]            state, nxt_state;
    logic [DATA_WIDTH-1:0] sh, nxt_sh;
    logic [3:0]            cnt, nxt_cnt, nbits_q;
    logic                  stop2_q, bit_end, accept, done, go_par, par_bit, nxt_tx;

    assign accept = state == S_IDLE && i_valid;

    uart_tx_bit_timer #(.OSR(OSR)) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear   (state == S_IDLE),
        .tick    (i_baud_tick),
        .bit_end (bit_end)
    );

`ifdef UART_TX_PARITY_EN
    logic                  par_en_q, par_q;
    logic [DATA_WIDTH-1:0] mask;
    assign mask = ~({DATA_WIDTH{1'b1}} << data_bit_count(data_bits_e'(i_data_bits)));
    // Parity is fixed at accept, so the PARITY state just replays it.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else if (accept) begin
            par_en_q <= i_parity_en;
            par_q    <= ^(i_data & mask) ^ i_parity_odd;
        end
    assign go_par  = par_en_q;
    assign par_bit = par_q;
`else
    logic unused_parity;
    assign unused_parity = i_parity_en ^ i_parity_odd;
    assign go_par  = 1'b0;
    assign par_bit = 1'b1;
`endif

    always_comb begin
        nxt_state = state;
        nxt_sh    = sh;
        nxt_cnt   = cnt;
        done      = 1'b0;
        case (state)
            S_IDLE: if (i_valid) begin
                nxt_state = S_START;
                nxt_sh    = i_data;
                nxt_cnt   = '0;
            end
            S_START: if (bit_end) nxt_state = S_DATA;
            S_DATA: if (bit_end) begin
                nxt_sh  = sh >> 1;
                nxt_cnt = cnt + 4'd1;
                if (cnt == nbits_q - 4'd1) begin
                    nxt_state = go_par ? S_PARITY : S_STOP;
                    nxt_cnt   = '0;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) nxt_state = S_STOP;
`endif
            S_STOP: if (bit_end) begin
                nxt_cnt = cnt + 4'd1;
                if (cnt == {3'b000, stop2_q}) begin
                    nxt_state = S_IDLE;
                    done      = 1'b1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // Line level is derived from the next state so o_tx is a clean register output.
    assign nxt_tx = nxt_state == S_START ? 1'b0 :
                    nxt_state == S_DATA ? nxt_sh[0] :
                    nxt_state == S_PARITY ? par_bit : 1'b1;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state   <= S_IDLE;
            sh      <= '0;
            cnt     <= '0;
            nbits_q <= '0;
            stop2_q <= 1'b0;
            o_tx    <= 1'b1;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state <= nxt_state;
            sh    <= nxt_sh;
            cnt   <= nxt_cnt;
            if (accept) begin
                nbits_q <= data_bit_count(data_bits_e'(i_data_bits));
                stop2_q <= i_stop_2;
            end
            o_tx    <= nxt_tx;
            o_ready <= nxt_state == S_IDLE;
            o_busy  <= nxt_state != S_IDLE;
            o_done  <= done;
        end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: scoreboard bench; each accepted byte queues its expected line waveform,
// and a monitor walks the serial line tick by tick against it.
module tb_uart_tx_core;
    localparam int OSR = 16;

    typedef struct packed {
        logic [15:0] bits;
        int          len;
        int          start_cyc;
        logic [7:0]  data;
    } frame_t;

    logic       i_clk = 1'b0, i_rst = 1'b0, i_baud_tick = 1'b0, i_valid = 1'b0;
    logic [7:0] i_data = '0;
    logic [1:0] i_data_bits = '0;
    logic       i_stop_2 = 1'b0, i_parity_en = 1'b0, i_parity_odd = 1'b0;
    logic       o_ready, o_tx, o_busy, o_done;

    int n_tests = 0, n_fail = 0, cyc = 0, tick_div = 1, tdiv_cnt = 0;
    frame_t q[$];
    frame_t cur;
    int tidx = 0;
    logic in_frame = 1'b0, exp_done = 1'b0, ferr = 1'b0;
    logic [15:0] obs = '0;

    uart_tx_core #(.OSR(OSR), .DATA_WIDTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_baud_tick(i_baud_tick), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready), .i_data_bits(i_data_bits), .i_stop_2(i_stop_2),
        .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .o_tx(o_tx),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    initial forever begin
        @(posedge i_clk);
        #1;
        tdiv_cnt = (tdiv_cnt + 1 >= tick_div) ? 0 : tdiv_cnt + 1;
        i_baud_tick = (tdiv_cnt == 0);
    end

    // Reference frame: start, N data bits LSB first, optional parity, 1 or 2 stop bits.
    function automatic frame_t model(input logic [7:0] d, input logic [1:0] nb,
                                     input logic s2, input logic pe, input logic po);
        frame_t f;
        int n;
        logic par;
        n = 5 + int'(nb);
        par = po;
        f.bits = '0;
        f.data = d;
        f.start_cyc = 0;
        for (int i = 0; i < n; i++) begin
            f.bits[1 + i] = d[i];
            par ^= d[i];
        end
        f.len = 1 + n;
`ifdef UART_TX_PARITY_EN
        if (pe) begin
            f.bits[f.len] = par;
            f.len++;
        end
`else
        if (pe && !pe) f.len = 0;
`endif
        for (int i = 0; i < (s2 ? 2 : 1); i++) begin
            f.bits[f.len] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    initial forever begin
        @(negedge i_clk);
        if (i_rst) begin
            in_frame = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (o_done || exp_done) begin
                n_tests++;
                if (!(o_done && exp_done && o_ready && !o_busy)) begin
                    n_fail++;
                    $display("FAIL done: o_done=%0b ready=%0b busy=%0b expected_done=%0b, required 1 1 0 at end of frame",
                             o_done, o_ready, o_busy, exp_done);
                end
                exp_done = 1'b0;
            end
            if (!in_frame && q.size() != 0 && cyc == q[0].start_cyc) begin
                cur = q.pop_front();
                in_frame = 1'b1;
                tidx = 0;
                obs = '0;
                ferr = 1'b0;
            end
            if (in_frame) begin
                if (o_tx !== cur.bits[tidx / OSR] || o_busy !== 1'b1 || o_ready !== 1'b0) ferr = 1'b1;
                if (tidx % OSR == OSR / 2) obs[tidx / OSR] = o_tx;
                if (i_baud_tick) tidx++;
                if (tidx == cur.len * OSR) begin
                    in_frame = 1'b0;
                    exp_done = 1'b1;
                    n_tests++;
                    if (ferr) begin
                        n_fail++;
                        $display("FAIL frame data=%h: line bits %b (len %0d), required %b", cur.data,
                                 obs, cur.len, cur.bits);
                    end
                end
            end else if (o_tx !== 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL idle_tx: o_tx=%b at cycle %0d, required 1", o_tx, cyc);
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] nb, input logic s2,
                        input logic pe, input logic po);
        frame_t f;
        int k;
        @(negedge i_clk);
        i_data = d;
        i_data_bits = nb;
        i_stop_2 = s2;
        i_parity_en = pe;
        i_parity_odd = po;
        i_valid = 1'b1;
        k = 0;
        while (!o_ready && k < 20000) begin
            @(negedge i_clk);
            k++;
        end
        if (!o_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: o_ready=%b, required 1", o_ready);
            i_valid = 1'b0;
        end else begin
            f = model(d, nb, s2, pe, po);
            f.start_cyc = cyc + 1;
            q.push_back(f);
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((q.size() != 0 || in_frame || exp_done) && k < 20000) begin
            @(negedge i_clk);
            k++;
        end
        if (k >= 20000) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: %0d frames pending, required 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic rst_check(input string name);
        n_tests++;
        if ({o_tx, o_ready, o_busy, o_done} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s: tx/ready/busy/done=%b, required 1100", name,
                     {o_tx, o_ready, o_busy, o_done});
        end
    endtask

    initial begin
        #2 i_rst = 1'b1;
        #1 rst_check("reset_values");
        repeat (3) @(posedge i_clk);
        #2 i_rst = 1'b0;
        repeat (3) @(negedge i_clk);

        send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
        wait_idle();
        send(8'hFF, 2'b00, 1'b1, 1'b0, 1'b0);
        wait_idle();
        send(8'h07, 2'b11, 1'b0, 1'b1, 1'b0);
        wait_idle();
        send(8'h07, 2'b11, 1'b0, 1'b1, 1'b1);
        wait_idle();

        send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0);
        send(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0);
        wait_idle();

        tick_div = 7;
        send(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge i_clk);
        i_data = 8'h33;
        i_data_bits = 2'b00;
        i_stop_2 = 1'b1;
        i_valid = 1'b1;
        repeat (100) @(negedge i_clk);
        i_valid = 1'b0;
        wait_idle();

        tick_div = 1;
        send(8'hC6, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (72) @(posedge i_clk);
        #2 i_rst = 1'b1;
        q.delete();
        #1 rst_check("reset_mid_data");
        repeat (3) @(posedge i_clk);
        #2 i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        send(8'h81, 2'b11, 1'b0, 1'b0, 1'b0);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            tick_div = int'($urandom_range(1, 3));
            send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        n_tests++;
        if (q.size() != 0 || in_frame) begin
            n_fail++;
            $display("FAIL pending: %0d frames outstanding, in_frame=%b, required 0 and 0", q.size(), in_frame);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule
